// File: rtl/serial_shift_ctrl_pkg.sv
// Shared definitions for the serial shift controller: state encoding,
// parameter limits and the bit-counter width helper.
package serial_shift_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;
    localparam int GAP_MAX   = 15;
    localparam int GAP_CNT_W = $clog2(GAP_MAX + 1);

    // Bit counter only has to reach WIDTH-1, so WIDTH=2 needs a single bit.
    function automatic int cnt_width(input int n);
        if (n <= WIDTH_MIN) return 1;
        if (n > WIDTH_MAX) return $clog2(WIDTH_MAX);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/serial_shift_ctrl_shift_chain.sv
// Loadable left-shift register assembled from single-bit D flip-flop cells;
// load wins over shift, and a zero enters at bit 0 on every shift.
module shift_chain_cell (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk) begin
        if (reset) q <= 1'b0;
        else       q <= d;
    end

endmodule

module shift_chain #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] cell_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        if (i == 0) begin : g_lsb
            assign cell_d[i] = load ? d[i] : (shift ? 1'b0 : q[i]);
        end else begin : g_upper
            assign cell_d[i] = load ? d[i] : (shift ? q[i-1] : q[i]);
        end

        shift_chain_cell u_cell (
            .clk   (clk),
            .reset (reset),
            .d     (cell_d[i]),
            .q     (q[i])
        );
    end

endmodule

// File: rtl/serial_shift_ctrl.sv
// Parallel-in, serial-out transmitter: accepts a word on valid/ready, shifts it
// out MSB first through shift_chain, then enforces GAP idle cycles.
module serial_shift_ctrl
    import serial_shift_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int GAP   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_start,
    output logic             done,
    output logic             busy
);

    localparam int            BW   = cnt_width(WIDTH);
    localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);

    state_t                 state;
    state_t                 state_nxt;
    logic [BW-1:0]          bit_cnt;
    logic [GAP_CNT_W-1:0]   gap_cnt;
    logic [WIDTH-1:0]       chain_q;
    logic                   last_bit;
    logic                   accept;
    logic                   shift;

    assign last_bit = (state == S_SHIFT) && (bit_cnt == LAST);
    assign accept   = in_valid && in_ready;
    // A reload in the back-to-back case replaces the shift on that edge.
    assign shift    = (state == S_SHIFT) && !accept;

    shift_chain #(.WIDTH(WIDTH)) u_chain (
        .clk   (clk),
        .reset (reset),
        .load  (accept),
        .shift (shift),
        .d     (in_data),
        .q     (chain_q)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt <= '0;
            gap_cnt <= '0;
        end else begin
            if (accept)
                bit_cnt <= '0;
            else if ((state == S_SHIFT) && !last_bit)
                bit_cnt <= bit_cnt + 1'b1;

            if (last_bit && (GAP > 0))
                gap_cnt <= GAP_CNT_W'(GAP - 1);
            else if ((state == S_GAP) && (gap_cnt != '0))
                gap_cnt <= gap_cnt - 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                if (last_bit) begin
                    if (GAP > 0)      state_nxt = S_GAP;
                    else if (!accept) state_nxt = S_IDLE;
                end
            end
            S_GAP: begin
                if (gap_cnt == '0) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready    = 1'b0;
        ser_valid   = (state == S_SHIFT);
        ser_out     = ser_valid && chain_q[WIDTH-1];
        frame_start = ser_valid && (bit_cnt == '0);
        done        = last_bit;
        busy        = (state == S_SHIFT) || (state == S_GAP);
        if (!reset)
            in_ready = (state == S_IDLE) || ((GAP == 0) && last_bit);
    end

endmodule
